// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard, stall/flush/freeze and forwarding control for a 5-stage MIPS pipeline
//
// Purpose: picks the pipeline action each cycle (RUN, STALL, FLUSH, MWAIT),
// drives the PC and IF/ID, ID/EX, EX/MEM, MEM/WB load enables and bubble
// strobes, keeps a shadow copy of in-flight destinations and produces the
// EX-stage forwarding selects.
//
// Build option: define HAZ_FORWARDING_EN to compile in EX forwarding. Only
// load-use then stalls. Without it every in-flight writer stalls the reader
// and fwd_a/fwd_b stay 00.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rs/rt    sources of the instruction in ID
//   id_dest, id_reg_write,
//   id_mem_read                    destination and control of the ID instruction
//   branch_taken                   EX resolved a taken branch
//   dmem_req, dmem_ready           data-memory handshake from MEM
//   pc_en, cfe_en, dex_en,
//   em_en, mw_en                   PC and buffer load enables
//   cfe_flush, dex_flush           bubble strobes for IF/ID and ID/EX
//   fwd_a, fwd_b                   00 regfile, 10 EX/MEM, 01 MEM/WB
//   state                          current action (debug)
//   stall_cycles, flush_count      saturating performance counters

module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [4:0]  id_dest,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        cfe_en,
  output logic        dex_en,
  output logic        em_en,
  output logic        mw_en,
  output logic        cfe_flush,
  output logic        dex_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10,
    ST_MWAIT = 2'b11
  } state_t;

  state_t cur_state, nxt_state;

  // Shadow pipeline entries
  logic       ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0] ex_dest;
`ifdef HAZ_FORWARDING_EN
  logic [4:0] ex_rs, ex_rt;
`endif
  logic       mem_valid, mem_reg_write;
  logic [4:0] mem_dest;
  logic       wb_valid, wb_reg_write;
  logic [4:0] wb_dest;

  logic hazard;
  logic mwait;

  // A source hits a writer only if it is used and nonzero; since dest must
  // equal that nonzero source, a dest of 0 can never count as a writer.
  function automatic logic src_hit(input logic used, input logic [4:0] src,
                                   input logic wv, input logic wrw,
                                   input logic [4:0] wd);
    return used && (src != 5'd0) && wv && wrw && (wd == src);
  endfunction

`ifdef HAZ_FORWARDING_EN
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic mv, input logic mrw, input logic [4:0] md,
                                         input logic wv, input logic wrw, input logic [4:0] wd);
    if (src_hit(1'b1, src, mv, mrw, md))
      return 2'b10;
    else if (src_hit(1'b1, src, wv, wrw, wd))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Only a load in EX cannot be forwarded in time for the ID consumer.
  assign hazard = ex_mem_read &&
                  (src_hit(id_uses_rs, id_rs, ex_valid, ex_reg_write, ex_dest) ||
                   src_hit(id_uses_rt, id_rt, ex_valid, ex_reg_write, ex_dest));
  assign fwd_a  = fwd_sel(ex_rs, mem_valid, mem_reg_write, mem_dest, wb_valid, wb_reg_write, wb_dest);
  assign fwd_b  = fwd_sel(ex_rt, mem_valid, mem_reg_write, mem_dest, wb_valid, wb_reg_write, wb_dest);
`else
  // The register file is not write-through, so a WB writer also blocks.
  assign hazard = src_hit(id_uses_rs, id_rs, ex_valid,  ex_reg_write,  ex_dest)  ||
                  src_hit(id_uses_rt, id_rt, ex_valid,  ex_reg_write,  ex_dest)  ||
                  src_hit(id_uses_rs, id_rs, mem_valid, mem_reg_write, mem_dest) ||
                  src_hit(id_uses_rt, id_rt, mem_valid, mem_reg_write, mem_dest) ||
                  src_hit(id_uses_rs, id_rs, wb_valid,  wb_reg_write,  wb_dest)  ||
                  src_hit(id_uses_rt, id_rt, wb_valid,  wb_reg_write,  wb_dest);
  assign fwd_a  = 2'b00;
  assign fwd_b  = 2'b00;
`endif

  assign mwait = dmem_req && !dmem_ready;
  assign state = cur_state;

  // Priority: memory freeze, then branch squash (which masks any hazard of
  // the squashed ID instruction), then data-hazard stall, then run.
  always_comb begin
    nxt_state = ST_RUN;
    pc_en     = 1'b1;
    cfe_en    = 1'b1;
    dex_en    = 1'b1;
    em_en     = 1'b1;
    mw_en     = 1'b1;
    cfe_flush = 1'b0;
    dex_flush = 1'b0;
    if (mwait) begin
      nxt_state = ST_MWAIT;
      pc_en     = 1'b0;
      cfe_en    = 1'b0;
      dex_en    = 1'b0;
      em_en     = 1'b0;
      mw_en     = 1'b0;
    end else if (branch_taken) begin
      nxt_state = ST_FLUSH;
      cfe_flush = 1'b1;
      dex_flush = 1'b1;
    end else if (hazard) begin
      nxt_state = ST_STALL;
      pc_en     = 1'b0;
      cfe_en    = 1'b0;
      dex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state     <= ST_RUN;
      stall_cycles  <= 16'd0;
      flush_count   <= 16'd0;
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_dest       <= 5'd0;
`ifdef HAZ_FORWARDING_EN
      ex_rs         <= 5'd0;
      ex_rt         <= 5'd0;
`endif
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_dest      <= 5'd0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_dest       <= 5'd0;
    end else begin
      cur_state <= nxt_state;
      if ((nxt_state == ST_STALL || nxt_state == ST_MWAIT) && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (nxt_state == ST_FLUSH && flush_count != 16'hFFFF)
        flush_count <= flush_count + 16'd1;

      // Bubble takes precedence over the load, matching the real ID/EX buffer.
      if (dex_flush) begin
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_dest      <= 5'd0;
`ifdef HAZ_FORWARDING_EN
        ex_rs        <= 5'd0;
        ex_rt        <= 5'd0;
`endif
      end else if (dex_en) begin
        ex_valid     <= 1'b1;
        ex_reg_write <= id_reg_write;
        ex_mem_read  <= id_mem_read;
        ex_dest      <= id_dest;
`ifdef HAZ_FORWARDING_EN
        ex_rs        <= id_rs;
        ex_rt        <= id_rt;
`endif
      end

      if (em_en) begin
        mem_valid     <= ex_valid;
        mem_reg_write <= ex_reg_write;
        mem_dest      <= ex_dest;
      end
      if (mw_en) begin
        wb_valid     <= mem_valid;
        wb_reg_write <= mem_reg_write;
        wb_dest      <= mem_dest;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed table-driven bench for pipe_hazard_ctrl
//
// Purpose: drives instruction/handshake vectors and compares strobes, forward
// selects, state and counters against hand-computed values.
// Ports: none (top-level bench).

module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic        branch_taken, dmem_req, dmem_ready;
  logic        pc_en, cfe_en, dex_en, em_en, mw_en, cfe_flush, dex_flush;
  logic [1:0]  fwd_a, fwd_b, state;
  logic [15:0] stall_cycles, flush_count;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .cfe_en(cfe_en), .dex_en(dex_en), .em_en(em_en), .mw_en(mw_en),
    .cfe_flush(cfe_flush), .dex_flush(dex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .state(state), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // {pc, cfe, dex, em, mw, cfe_flush, dex_flush, fwd_a[1:0], fwd_b[1:0]}
  logic [10:0] outs;
  assign outs = {pc_en, cfe_en, dex_en, em_en, mw_en, cfe_flush, dex_flush, fwd_a, fwd_b};

  localparam logic [10:0] O_RUN   = 11'b11111_00_00_00;
  localparam logic [10:0] O_STALL = 11'b00111_01_00_00;
  localparam logic [10:0] O_FLUSH = 11'b11111_11_00_00;
  localparam logic [10:0] O_MWAIT = 11'b00000_00_00_00;
  localparam logic [10:0] F_A01   = 11'd4;
  localparam logic [10:0] F_AB10  = 11'd10;

  typedef struct {
    logic [4:0]  rs, rt, dest;
    logic        urs, urt, rw, mr, br, dreq, drdy;
    logic [10:0] exp_out;
    logic [1:0]  exp_st;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt,
                              input logic [4:0] dest, input logic rw, input logic mr,
                              input logic br, input logic dreq, input logic drdy,
                              input logic [10:0] eo, input logic [1:0] es);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.dest = dest;
    v.rw = rw; v.mr = mr; v.br = br; v.dreq = dreq; v.drdy = drdy;
    v.exp_out = eo; v.exp_st = es;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
    id_dest = v.dest; id_reg_write = v.rw; id_mem_read = v.mr;
    branch_taken = v.br; dmem_req = v.dreq; dmem_ready = v.drdy;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    @(negedge clk);
    drive(v);
    #1 chk({nm, " outs"}, 32'(outs), 32'(v.exp_out));
    @(posedge clk);
    #1 chk({nm, " state"}, 32'(state), 32'(v.exp_st));
  endtask

  task automatic do_reset(input vec_t v);
    @(negedge clk);
    rst = 1'b1;
    drive(v);
    @(posedge clk);
    #1;
    chk("reset state", 32'(state), 32'd0);
    chk("reset stall_cycles", 32'(stall_cycles), 32'd0);
    chk("reset flush_count", 32'(flush_count), 32'd0);
    rst = 1'b0;
  endtask

  vec_t idle, mw_br, mw, rdy_br, lw5, rd5;

  initial begin
    idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,   2'b00);
    mw_br  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_MWAIT, 2'b11);
    mw     = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_MWAIT, 2'b11);
    rdy_br = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, O_FLUSH, 2'b10);
    lw5    = mk(0, 0, 0, 0, 5, 1, 1, 0, 0, 0, O_RUN,   2'b00);
    rd5    = mk(5, 0, 1, 0, 0, 0, 0, 0, 0, 0, O_RUN,   2'b00);

`ifdef HAZ_FORWARDING_EN
    tbl.push_back(mk(1, 0, 1, 0, 2, 1, 1, 0, 0, 0, O_RUN,          2'b00)); // lw $2
    tbl.push_back(mk(2, 4, 1, 1, 3, 1, 0, 0, 0, 0, O_STALL,        2'b01)); // add $3,$2,$4
    tbl.push_back(mk(2, 4, 1, 1, 3, 1, 0, 0, 0, 0, O_RUN,          2'b00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN | F_A01,  2'b00)); // add in EX, lw in WB
    tbl.push_back(mk(1, 1, 1, 1, 5, 1, 0, 0, 0, 0, O_RUN,          2'b00)); // add $5
    tbl.push_back(mk(5, 5, 1, 1, 6, 1, 0, 0, 0, 0, O_RUN,          2'b00)); // sub $6,$5,$5
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN | F_AB10, 2'b00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, O_RUN,          2'b00)); // write $0
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, O_RUN,          2'b00)); // read $0
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,          2'b00));
    tbl.push_back(mk(1, 1, 1, 1, 8, 1, 0, 0, 0, 0, O_RUN,          2'b00)); // add $8
    tbl.push_back(mk(1, 1, 1, 1, 8, 1, 0, 0, 0, 0, O_RUN,          2'b00)); // add $8 again
    tbl.push_back(mk(8, 8, 1, 1, 10, 1, 0, 0, 0, 0, O_RUN,         2'b00)); // use $8
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN | F_AB10, 2'b00)); // MEM beats WB
    tbl.push_back(mk(0, 0, 0, 0, 9, 1, 1, 0, 0, 0, O_RUN,          2'b00)); // lw $9
    tbl.push_back(mk(9, 0, 1, 0, 0, 0, 0, 1, 0, 0, O_FLUSH,        2'b10)); // branch + load-use
    tbl.push_back(mk(9, 0, 1, 0, 0, 0, 0, 0, 0, 0, O_RUN,          2'b00)); // sEX squashed
`else
    tbl.push_back(mk(1, 1, 1, 1, 5, 1, 0, 0, 0, 0, O_RUN,   2'b00)); // add $5
    tbl.push_back(mk(5, 1, 1, 1, 7, 1, 0, 0, 0, 0, O_STALL, 2'b01)); // or $7,$5,$1
    tbl.push_back(mk(5, 1, 1, 1, 7, 1, 0, 0, 0, 0, O_STALL, 2'b01));
    tbl.push_back(mk(5, 1, 1, 1, 7, 1, 0, 0, 0, 0, O_STALL, 2'b01));
    tbl.push_back(mk(5, 1, 1, 1, 7, 1, 0, 0, 0, 0, O_RUN,   2'b00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, O_RUN,   2'b00)); // write $0
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, O_RUN,   2'b00)); // read $0
    tbl.push_back(mk(7, 0, 1, 0, 9, 1, 1, 1, 0, 0, O_FLUSH, 2'b10)); // branch + hazard on $7
    tbl.push_back(mk(9, 0, 1, 0, 0, 0, 0, 0, 0, 0, O_RUN,   2'b00)); // squashed $9 writer
`endif

    rst = 1'b0;
    drive(idle);
    do_reset(idle);
    #1 chk("reset outs", 32'(outs), 32'(O_RUN));

    foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

`ifdef HAZ_FORWARDING_EN
    chk("table stall_cycles", 32'(stall_cycles), 32'd1);
`else
    chk("table stall_cycles", 32'(stall_cycles), 32'd3);
`endif
    chk("table flush_count", 32'(flush_count), 32'd1);

    // Memory freeze with a pending branch, then flush when memory completes
    do_reset(idle);
    for (int k = 0; k < 4; k++) run_vec($sformatf("mwait%0d", k), mw_br);
    chk("mwait stall_cycles", 32'(stall_cycles), 32'd4);
    chk("mwait flush_count", 32'(flush_count), 32'd0);
    run_vec("mwait release", rdy_br);
    chk("release flush_count", 32'(flush_count), 32'd1);
    chk("release stall_cycles", 32'(stall_cycles), 32'd4);

    // Reset in the middle of a freeze with a load held in sEX
    do_reset(idle);
    run_vec("lw5", lw5);
    run_vec("mw0", mw);
    run_vec("mw1", mw);
    chk("pre-reset stall_cycles", 32'(stall_cycles), 32'd2);
    do_reset(mw);
    run_vec("post-reset read $5", rd5);
    chk("post-reset stall_cycles", 32'(stall_cycles), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
